// File: rtl/jp_pad_emu_if.sv
// Button-side and console-side signals of one emulated NES joypad.
// The master drives the buttons and the console pins; the slave (the pad) returns serial data and debounced state.
interface jp_pad_emu_if;
    logic [7:0] btn_in;
    logic [1:0] turbo_en_in;
    logic       jp_latch_in;
    logic       jp_clk_in;
    logic       jp_data_out;
    logic [7:0] btn_state_out;

    modport master (
        output btn_in, turbo_en_in, jp_latch_in, jp_clk_in,
        input  jp_data_out, btn_state_out
    );

    modport slave (
        input  btn_in, turbo_en_in, jp_latch_in, jp_clk_in,
        output jp_data_out, btn_state_out
    );
endinterface

// File: rtl/jp_pad_emu.sv
// Purpose: NES controller emulation: debounced buttons, optional A/B turbo, latch/shift serial readout.
// Latency: 4 clk_in cycles from a console pin edge to the matching jp_data_out change.
// Backpressure: none; the console paces reads with jp_latch/jp_clk and every synced clk edge is served.
module jp_pad_emu #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TURBO_PERIOD    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    jp_pad_emu_if.slave pad
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TC_W  = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TC_W-1:0]  TC_MAX = TC_W'(TURBO_PERIOD - 1);

    logic [CNT_W-1:0] db_cnt [8];
    logic [7:0]       btn_state;
    logic [1:0]       latch_sync;
    logic [1:0]       clk_sync;
    logic             latch_q;
    logic             clk_q;
    logic [TC_W-1:0]  turbo_cnt;
    logic             turbo_phase;
    logic [7:0]       shift_reg;
    logic             data_q;
    logic [7:0]       eff;
    logic             latch_lvl;
    logic             latch_fall;
    logic             clk_rise;

    // Per-bit debounce: the counter only runs while the raw level disagrees with the accepted one.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
            btn_state <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pad.btn_in[i] == btn_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    btn_state[i] <= pad.btn_in[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            latch_sync <= '0;
            clk_sync   <= '0;
            latch_q    <= 1'b0;
            clk_q      <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[0], pad.jp_latch_in};
            clk_sync   <= {clk_sync[0], pad.jp_clk_in};
            latch_q    <= latch_sync[1];
            clk_q      <= clk_sync[1];
        end
    end

    assign latch_lvl  = latch_sync[1];
    assign latch_fall = latch_q & ~latch_sync[1];
    assign clk_rise   = clk_sync[1] & ~clk_q;

    // Turbo phase advances once per completed latch frame.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (latch_fall) begin
            if (turbo_cnt == TC_MAX) begin
                turbo_cnt   <= '0;
                turbo_phase <= ~turbo_phase;
            end else begin
                turbo_cnt <= turbo_cnt + TC_W'(1);
            end
        end
    end

    always_comb begin
        eff    = btn_state;
        eff[0] = btn_state[0] & ~(pad.turbo_en_in[0] & turbo_phase);
        eff[1] = btn_state[1] & ~(pad.turbo_en_in[1] & turbo_phase);
    end

    // Latch high overrides shifting; zeros fill in so reads past bit 7 see a low pin.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shift_reg <= 8'hFF;
            data_q    <= 1'b1;
        end else begin
            if (latch_lvl) begin
                shift_reg <= ~eff;
            end else if (clk_rise) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
            data_q <= shift_reg[0];
        end
    end

    assign pad.jp_data_out   = data_q;
    assign pad.btn_state_out = btn_state;
endmodule
